// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: handshaked ALU control decoder for the execute stage.
// Decodes {alu_op, funct} into a 3-bit ALU control word. MUL/DIV requests
// occupy the block for MULDIV_CYCLES cycles, strobe the mul/div unit once,
// and only then present their control word. Illegal requests are counted.
module alu_ctrl_seq #(
  parameter int FUNCT_W       = 3,
  parameter int MULDIV_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         alu_control,
  output logic               illegal,
  output logic               md_start,
  output logic               busy,
  output logic [ERR_W-1:0]   err_count
);

  typedef enum logic {IDLE = 1'b0, MULTI = 1'b1} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] count;
  logic [2:0] pend_ctrl;
  logic       accept;
  logic [2:0] dec_ctrl;
  logic       dec_illegal;
  logic       dec_multi;

  // Decode result packed as {multi, illegal, control}. Any bit of funct
  // above [2:0] being set makes an R-type or logical request illegal.
  function automatic logic [4:0] decode(input logic [1:0] op,
                                        input logic [FUNCT_W-1:0] fn);
    logic [2:0] f;
    logic       hi_zero;
    logic [4:0] r;
    f       = fn[2:0];
    hi_zero = ((fn >> 3) == '0);
    r       = 5'b01_000;
    case (op)
      2'b00: r = 5'b00_001;
      2'b01: r = 5'b00_010;
      2'b10: begin
        if (hi_zero) begin
          case (f)
            3'b000:  r = 5'b00_001;
            3'b010:  r = 5'b00_010;
            3'b100:  r = 5'b00_011;
            3'b101:  r = 5'b00_100;
            3'b110:  r = 5'b00_101;
            3'b001:  r = 5'b10_110;
            3'b011:  r = 5'b10_111;
            default: r = 5'b01_000;
          endcase
        end
      end
      default: begin
        if (hi_zero) begin
          case (f)
            3'b100:  r = 5'b00_011;
            3'b101:  r = 5'b00_100;
            default: r = 5'b01_000;
          endcase
        end
      end
    endcase
    return r;
  endfunction

  // Saturating increment for the illegal-request counter.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + ERR_W'(1);
  endfunction

  // Decode the request currently on the inputs.
  always_comb begin
    {dec_multi, dec_illegal, dec_ctrl} = decode(alu_op, funct);
  end

  assign accept = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state: enter MULTI on a mul/div accept, leave when the count expires.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && dec_multi) state_next = MULTI;
      MULTI:   if (count == 8'd0)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-derived outputs: accept only when idle and the output slot is free.
  always_comb begin
    in_ready = (state == IDLE) && (!out_valid || out_ready);
    busy     = (state == MULTI);
  end

  // Cycle counter, start strobe, output slot and error counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= 8'd0;
      pend_ctrl   <= 3'b000;
      md_start    <= 1'b0;
      out_valid   <= 1'b0;
      alu_control <= 3'b000;
      illegal     <= 1'b0;
      err_count   <= '0;
    end else begin
      md_start <= accept && dec_multi;
      if (accept && dec_multi) begin
        count     <= CNT_LOAD;
        pend_ctrl <= dec_ctrl;
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        alu_control <= dec_ctrl;
        illegal     <= dec_illegal;
        if (dec_illegal) err_count <= sat_inc(err_count);
      end else if (state == MULTI) begin
        if (count == 8'd0) begin
          out_valid   <= 1'b1;
          alu_control <= pend_ctrl;
          illegal     <= 1'b0;
        end else begin
          count <= count - 8'd1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: instance A uses default parameters,
// instance B uses FUNCT_W=6, MULDIV_CYCLES=1, ERR_W=2.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic       a_in_valid = 0, a_out_ready = 0;
  logic [1:0] a_alu_op = 0;
  logic [2:0] a_funct = 0;
  logic       a_in_ready, a_out_valid, a_illegal, a_md_start, a_busy;
  logic [2:0] a_alu_control;
  logic [7:0] a_err_count;

  logic       b_in_valid = 0, b_out_ready = 0;
  logic [1:0] b_alu_op = 0;
  logic [5:0] b_funct = 0;
  logic       b_in_ready, b_out_valid, b_illegal, b_md_start, b_busy;
  logic [2:0] b_alu_control;
  logic [1:0] b_err_count;

  always #5 clk = ~clk;

  alu_ctrl_seq dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .alu_op(a_alu_op), .funct(a_funct), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .alu_control(a_alu_control), .illegal(a_illegal), .md_start(a_md_start),
    .busy(a_busy), .err_count(a_err_count));

  alu_ctrl_seq #(.FUNCT_W(6), .MULDIV_CYCLES(1), .ERR_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .alu_op(b_alu_op), .funct(b_funct), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .alu_control(b_alu_control), .illegal(b_illegal), .md_start(b_md_start),
    .busy(b_busy), .err_count(b_err_count));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({a_out_valid, a_alu_control, a_illegal, a_md_start, a_busy, a_in_ready} !== 8'b0_000_0_0_0_1) begin
      errors++;
      $display("FAIL reset_a_outputs: got %b exp 00000001",
               {a_out_valid, a_alu_control, a_illegal, a_md_start, a_busy, a_in_ready});
    end
    checks++;
    if (a_err_count !== 8'd0) begin
      errors++; $display("FAIL reset_a_err: got %0d exp 0", a_err_count);
    end
    checks++;
    if ({b_out_valid, b_alu_control, b_illegal, b_md_start, b_busy, b_err_count} !== 9'd0) begin
      errors++;
      $display("FAIL reset_b_outputs: got %b exp 000000000",
               {b_out_valid, b_alu_control, b_illegal, b_md_start, b_busy, b_err_count});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_rtype_stream;
    logic [2:0] fv [5];
    logic [2:0] ev [5];
    fv = '{3'b000, 3'b010, 3'b100, 3'b101, 3'b110};
    ev = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    a_out_ready = 1'b1;
    a_alu_op = 2'b10;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_funct = fv[i];
      checks++;
      if (a_in_ready !== 1'b1) begin
        errors++; $display("FAIL stream_in_ready[%0d]: got %b exp 1", i, a_in_ready);
      end
      tick();
      checks++;
      if ({a_out_valid, a_alu_control, a_illegal} !== {1'b1, ev[i], 1'b0}) begin
        errors++;
        $display("FAIL stream_out[%0d]: got v=%b ctrl=%b ill=%b exp v=1 ctrl=%b ill=0",
                 i, a_out_valid, a_alu_control, a_illegal, ev[i]);
      end
    end
    a_in_valid = 1'b0;
    tick();
    checks++;
    if ({a_out_valid, a_alu_control} !== 4'b0_101) begin
      errors++; $display("FAIL stream_drain: got v=%b ctrl=%b exp v=0 ctrl=101", a_out_valid, a_alu_control);
    end
  endtask

  task automatic test_multi;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_alu_op = 2'b10; a_funct = 3'b001;
    tick();
    // keep an ADD request pending; it must wait out the MUL
    a_alu_op = 2'b00; a_funct = 3'b000;
    checks++;
    if ({a_md_start, a_busy, a_in_ready, a_out_valid} !== 4'b1100) begin
      errors++; $display("FAIL mul_cycle1: got md/busy/rdy/v=%b exp 1100",
                         {a_md_start, a_busy, a_in_ready, a_out_valid});
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      checks++;
      if ({a_md_start, a_busy, a_in_ready, a_out_valid} !== 4'b0100) begin
        errors++; $display("FAIL mul_cycle%0d: got md/busy/rdy/v=%b exp 0100", k,
                           {a_md_start, a_busy, a_in_ready, a_out_valid});
      end
    end
    tick();
    checks++;
    if ({a_md_start, a_busy, a_out_valid, a_alu_control, a_illegal, a_in_ready} !== 8'b0_0_1_110_0_1) begin
      errors++; $display("FAIL mul_result: got %b exp 00111001",
                         {a_md_start, a_busy, a_out_valid, a_alu_control, a_illegal, a_in_ready});
    end
    tick();
    checks++;
    if ({a_out_valid, a_alu_control} !== 4'b1_001) begin
      errors++; $display("FAIL mul_then_add: got v=%b ctrl=%b exp v=1 ctrl=001", a_out_valid, a_alu_control);
    end
    // DIV on instance A
    a_alu_op = 2'b10; a_funct = 3'b011;
    tick();
    a_in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL div_early: got v=%b exp 0", a_out_valid);
    end
    tick();
    checks++;
    if ({a_out_valid, a_alu_control, a_busy} !== 5'b1_111_0) begin
      errors++; $display("FAIL div_result: got v=%b ctrl=%b busy=%b exp v=1 ctrl=111 busy=0",
                         a_out_valid, a_alu_control, a_busy);
    end
    tick();
    // MUL on instance B with a one-cycle occupancy
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_alu_op = 2'b10; b_funct = 6'b000001;
    tick();
    b_in_valid = 1'b0;
    checks++;
    if ({b_md_start, b_busy, b_in_ready, b_out_valid} !== 4'b1100) begin
      errors++; $display("FAIL mul1_cycle1: got md/busy/rdy/v=%b exp 1100",
                         {b_md_start, b_busy, b_in_ready, b_out_valid});
    end
    tick();
    checks++;
    if ({b_md_start, b_busy, b_out_valid, b_alu_control} !== 6'b0_0_1_110) begin
      errors++; $display("FAIL mul1_result: got %b exp 001110",
                         {b_md_start, b_busy, b_out_valid, b_alu_control});
    end
    tick();
  endtask

  task automatic test_hold;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_alu_op = 2'b00; a_funct = 3'b101;
    tick();
    tick();
    a_alu_op = 2'b01;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({a_out_valid, a_alu_control, a_in_ready} !== 5'b1_001_0) begin
        errors++; $display("FAIL hold[%0d]: got v=%b ctrl=%b rdy=%b exp v=1 ctrl=001 rdy=0",
                           k, a_out_valid, a_alu_control, a_in_ready);
      end
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release_ready: got %b exp 1", a_in_ready);
    end
    tick();
    checks++;
    if ({a_out_valid, a_alu_control} !== 4'b1_010) begin
      errors++; $display("FAIL hold_pending_sub: got v=%b ctrl=%b exp v=1 ctrl=010", a_out_valid, a_alu_control);
    end
    a_in_valid = 1'b0;
    tick();
    checks++;
    if ({a_out_valid, a_alu_control} !== 4'b0_010) begin
      errors++; $display("FAIL hold_clear: got v=%b ctrl=%b exp v=0 ctrl=010", a_out_valid, a_alu_control);
    end
  endtask

  task automatic test_illegal;
    logic [1:0] op [5];
    logic [2:0] fn [5];
    logic [4:0] ex [5];
    logic [7:0] er [5];
    logic [1:0] bop [5];
    logic [5:0] bfn [5];
    logic [1:0] ber [5];
    op = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    fn = '{3'b111, 3'b000, 3'b111, 3'b100, 3'b101};
    ex = '{5'b1_000_1, 5'b1_000_1, 5'b1_000_1, 5'b1_011_0, 5'b1_100_0};
    er = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1; a_alu_op = op[i]; a_funct = fn[i];
      tick();
      checks++;
      if ({a_out_valid, a_alu_control, a_illegal} !== ex[i] || a_err_count !== er[i]) begin
        errors++; $display("FAIL illegal_a[%0d]: got v/ctrl/ill=%b err=%0d exp %b err=%0d",
                           i, {a_out_valid, a_alu_control, a_illegal}, a_err_count, ex[i], er[i]);
      end
    end
    a_in_valid = 1'b0;
    tick();
    bop = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    bfn = '{6'b001000, 6'b001000, 6'b000111, 6'b000000, 6'b100010};
    ber = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_in_valid = 1'b1; b_alu_op = bop[i]; b_funct = bfn[i];
      tick();
      checks++;
      if ({b_out_valid, b_alu_control, b_illegal} !== 5'b1_000_1 || b_err_count !== ber[i]) begin
        errors++; $display("FAIL illegal_b[%0d]: got v/ctrl/ill=%b err=%0d exp 10001 err=%0d",
                           i, {b_out_valid, b_alu_control, b_illegal}, b_err_count, ber[i]);
      end
    end
    b_in_valid = 1'b0;
    tick();
  endtask

  task automatic test_funct_ignored;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_alu_op = (i % 2 == 0) ? 2'b00 : 2'b01;
      a_funct = 3'($urandom_range(0, 7));
      tick();
      checks++;
      if ({a_out_valid, a_alu_control, a_illegal} !== ((i % 2 == 0) ? 5'b1_001_0 : 5'b1_010_0)) begin
        errors++; $display("FAIL addsub_a[%0d]: got v/ctrl/ill=%b funct=%b", i,
                           {a_out_valid, a_alu_control, a_illegal}, a_funct);
      end
    end
    a_in_valid = 1'b0;
    b_in_valid = 1'b1; b_alu_op = 2'b01; b_funct = 6'($urandom_range(8, 63));
    tick();
    b_in_valid = 1'b0;
    checks++;
    if ({b_out_valid, b_alu_control, b_illegal} !== 5'b1_010_0) begin
      errors++; $display("FAIL sub_b_wide_funct: got v/ctrl/ill=%b exp 10100",
                         {b_out_valid, b_alu_control, b_illegal});
    end
    checks++;
    if (a_err_count !== 8'd3 || b_err_count !== 2'd3) begin
      errors++; $display("FAIL err_unchanged: got a=%0d b=%0d exp a=3 b=3", a_err_count, b_err_count);
    end
    tick();
  endtask

  task automatic test_reset_abort;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_alu_op = 2'b10; a_funct = 3'b011;
    tick();
    a_in_valid = 1'b0;
    checks++;
    if (a_md_start !== 1'b1) begin
      errors++; $display("FAIL abort_start: got md=%b exp 1", a_md_start);
    end
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_alu_control, a_illegal, a_md_start, a_busy} !== 7'd0 || a_err_count !== 8'd0) begin
      errors++; $display("FAIL abort_async: got v/ctrl/ill/md/busy=%b err=%0d exp 0000000 err=0",
                         {a_out_valid, a_alu_control, a_illegal, a_md_start, a_busy}, a_err_count);
    end
    checks++;
    if (b_err_count !== 2'd0) begin
      errors++; $display("FAIL abort_b_err: got %0d exp 0", b_err_count);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({a_out_valid, a_md_start, a_busy, a_in_ready} !== 4'b0001) begin
        errors++; $display("FAIL abort_after[%0d]: got v/md/busy/rdy=%b exp 0001", k,
                           {a_out_valid, a_md_start, a_busy, a_in_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype_stream();
    test_multi();
    test_hold();
    test_illegal();
    test_funct_ignored();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
